acc_exec8: RTL and testbench
============================

Name: acc_exec8

Overview:
- Accumulator/execute sequencer that sits on both sides of the 8-bit ALU (alu8).
- Upstream, it accepts one operation per valid/ready handshake and drives the ALU operand, op and carry-in pins.
- It holds those pins stable for a programmable settle time, then captures ALU Y/Cout into an 8-bit accumulator and a flags register.
- The accumulator feeds back as ALU operand A, giving the CPU a single-accumulator execute stage.

Parameters:
- SETTLE_CYCLES, 1, cycles ALU inputs are held before result capture (gate-level propagation margin); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  high when able to accept (state IDLE)
- in_op  in  3  ALU op code, passed through to alu_op (3'b000 = add)
- in_operand  in  8  operand B, or load value
- in_use_carry  in  1  1: alu_cin = current flag_c; 0: alu_cin = 0
- in_load  in  1  1: acc <= in_operand directly, ALU bypassed
- alu_a  out  8  ALU operand A (= acc)
- alu_b  out  8  ALU operand B (registered)
- alu_op  out  3  ALU op (registered)
- alu_cin  out  1  ALU carry-in (registered)
- alu_y  in  8  ALU result
- alu_cout  in  1  ALU carry-out
- acc  out  8  accumulator
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- flag_n  out  1  negative flag (acc[7])
- done  out  1  one-cycle pulse when result written

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state IDLE; acc, alu_b, alu_op, alu_cin, flag_c, flag_z, flag_n, done all 0.
  - in_ready = 1 after reset; flag_z = 0 at reset, not derived from acc.
- States:
  - IDLE: in_ready=1. On in_valid at edge E0:
    - latch alu_b <= in_operand, alu_op <= in_op, alu_cin <= in_use_carry & flag_c, load_q <= in_load.
    - load the settle counter with SETTLE_CYCLES-1 and go to EXEC.
  - EXEC: in_ready=0; counter decrements each edge; at 0 go to WB.
  - WB: in_ready=0. On the edge:
    - load_q=0: acc <= alu_y, flag_c <= alu_cout.
    - load_q=1: acc <= alu_b, flag_c unchanged.
    - Both cases: flag_z <= (new acc == 0), flag_n <= new acc[7], done <= 1, go to IDLE.
- Latency and ready:
  - The write edge is E0 + SETTLE_CYCLES + 1.
  - done is high for exactly the following cycle, during which in_ready=1.
  - A new op may be accepted on the edge that ends that cycle.
- done is registered, cleared on every edge where no write occurs.
- in_valid while in_ready=0 is ignored; nothing is queued or latched. The requester must hold in_valid until accepted.
- alu_b, alu_op and alu_cin are stable from E0 through the write edge. They hold their last values while IDLE.
- alu_a is combinational from acc, so it changes only at write edges.
- Arithmetic is done entirely by the ALU; this block adds no width extension.
- Reset mid-EXEC or mid-WB: immediate return to reset values. No partial write; done not asserted.

Optional Feature:
- Macro ACC_EXEC8_OVF_FLAG_EN.
- Defined:
  - Extra output flag_v (1 bit, reset 0).
  - On a non-load write with alu_op==3'b000: flag_v <= (alu_a[7]==alu_b[7]) & (alu_y[7]!=alu_a[7]).
  - Other non-load ops: flag_v <= 0. Load: flag_v unchanged.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Load then add, SETTLE_CYCLES=1:
  - Stimulus: load 7, then add (op 000, use_carry=0) with operand 8.
  - Response: acc=15, C=0, Z=0, N=0; done one cycle after write edge E0+2; in_ready low for 2 cycles per op.
- Carry out: load 200, add 100 -> acc=44, C=1, Z=0, N=0.
- Carry chain, continuing from C=1:
  - load 0 -> C stays 1, Z=1.
  - add 0 with use_carry=1 -> alu_cin=1, acc=1, C=0, Z=0.
- Back-pressure, SETTLE_CYCLES=3: in_valid pulsed with operand 99 while in EXEC -> ignored; acc unaffected; in_ready stays 0 for 4 cycles after accept.
- Reset mid-op: assert rst_n=0 during EXEC -> acc=0, all flags 0, done never pulses, in_ready=1 immediately; after release, load 5 completes normally.
- With ACC_EXEC8_OVF_FLAG_EN: load 100, add 100 -> acc=200, N=1, C=0, flag_v=1.

Source files
------------

// File: rtl/acc_exec8.sv
// -----------------------------------------------------------------------------
// acc_exec8 : single-accumulator execute sequencer wrapped around an external
//             8-bit ALU (alu8).
//
// One operation is accepted per in_valid/in_ready handshake. The ALU input pins
// are then held stable for SETTLE_CYCLES cycles, after which ALU Y/Cout are
// captured into the accumulator and the flags. A load operation bypasses the
// ALU and writes the operand straight into the accumulator.
//
// Parameter
//   SETTLE_CYCLES  cycles the ALU inputs settle before capture (1..15)
//
// Optional feature
//   ACC_EXEC8_OVF_FLAG_EN  when defined, adds the signed-overflow flag flag_v
//                          (updated on add, cleared on other ALU ops, held on
//                          loads)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (ready only while IDLE)
//   in_op, in_operand   ALU op code and operand B / load value
//   in_use_carry        feed the current carry flag into alu_cin
//   in_load             write in_operand directly to the accumulator
//   alu_a/b/op/cin      ALU input pins (a = accumulator, rest registered)
//   alu_y, alu_cout     ALU result pins
//   acc                 accumulator
//   flag_c/z/n          carry, zero, negative flags
//   flag_v              signed overflow flag (feature builds only)
//   done                one-cycle pulse following each accumulator write
// -----------------------------------------------------------------------------
module acc_exec8 #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [7:0] in_operand,
    input  logic       in_use_carry,
    input  logic       in_load,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic       alu_cin,
    input  logic [7:0] alu_y,
    input  logic       alu_cout,
    output logic [7:0] acc,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_n,
    output logic       done
`ifdef ACC_EXEC8_OVF_FLAG_EN
    ,
    output logic       flag_v
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       load_q;
    logic [7:0] wb_acc_d;

    // Value written to the accumulator in WB: loads bypass the ALU.
    assign wb_acc_d = load_q ? alu_b : alu_y;

    assign alu_a    = acc;
    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            load_q  <= 1'b0;
            alu_b   <= 8'd0;
            alu_op  <= 3'd0;
            alu_cin <= 1'b0;
            acc     <= 8'd0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            done    <= 1'b0;
`ifdef ACC_EXEC8_OVF_FLAG_EN
            flag_v  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        alu_b   <= in_operand;
                        alu_op  <= in_op;
                        alu_cin <= in_use_carry & flag_c;
                        load_q  <= in_load;
                        cnt_q   <= CNT_INIT;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= WB;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WB: begin
                    acc    <= wb_acc_d;
                    flag_z <= (wb_acc_d == 8'd0);
                    flag_n <= wb_acc_d[7];
                    done   <= 1'b1;
                    if (!load_q) begin
                        flag_c <= alu_cout;
`ifdef ACC_EXEC8_OVF_FLAG_EN
                        // Signed overflow: like-signed operands, result sign differs.
                        if (alu_op == 3'b000) begin
                            flag_v <= (acc[7] == alu_b[7]) & (alu_y[7] != acc[7]);
                        end else begin
                            flag_v <= 1'b0;
                        end
`endif
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_exec8.sv
module tb_acc_exec8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance with SETTLE_CYCLES = 1
    logic       v1, rdy1, uc1, ld1, cin1, co1, c1, z1, n1, d1;
    logic [2:0] op1s, aop1;
    logic [7:0] opd1, a1, b1, y1, acc1;
    // Instance with SETTLE_CYCLES = 3
    logic       v3, rdy3, uc3, ld3, cin3, co3, c3, z3, n3, d3;
    logic [2:0] op3s, aop3;
    logic [7:0] opd3, a3, b3, y3, acc3;
`ifdef ACC_EXEC8_OVF_FLAG_EN
    logic       fv1, fv3;
`endif

    acc_exec8 #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_op(op1s),
        .in_operand(opd1), .in_use_carry(uc1), .in_load(ld1), .alu_a(a1), .alu_b(b1),
        .alu_op(aop1), .alu_cin(cin1), .alu_y(y1), .alu_cout(co1), .acc(acc1),
        .flag_c(c1), .flag_z(z1), .flag_n(n1), .done(d1)
`ifdef ACC_EXEC8_OVF_FLAG_EN
        , .flag_v(fv1)
`endif
    );

    acc_exec8 #(.SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_op(op3s),
        .in_operand(opd3), .in_use_carry(uc3), .in_load(ld3), .alu_a(a3), .alu_b(b3),
        .alu_op(aop3), .alu_cin(cin3), .alu_y(y3), .alu_cout(co3), .acc(acc3),
        .flag_c(c3), .flag_z(z3), .flag_n(n3), .done(d3)
`ifdef ACC_EXEC8_OVF_FLAG_EN
        , .flag_v(fv3)
`endif
    );

    // Behavioural stand-in for alu8: op 000 adds with carry, others XOR.
    always_comb begin
        if (aop1 == 3'b000) {co1, y1} = {1'b0, a1} + {1'b0, b1} + {8'd0, cin1};
        else                {co1, y1} = {1'b0, a1 ^ b1};
        if (aop3 == 3'b000) {co3, y3} = {1'b0, a3} + {1'b0, b3} + {8'd0, cin3};
        else                {co3, y3} = {1'b0, a3 ^ b3};
    end

    // Issue one op to u1; report edges-to-done, ready-low cycles and pins seen after accept.
    task automatic op1(input logic ld, input logic [2:0] op, input logic [7:0] opd,
                       input logic uc, output int lat, output int lowc,
                       output logic cin_seen, output logic [7:0] b_seen);
        int k;
        k = 0;
        while (!rdy1 && k < 50) begin @(posedge clk); #1; k++; end
        v1 = 1'b1; ld1 = ld; op1s = op; opd1 = opd; uc1 = uc;
        @(posedge clk); #1;
        v1 = 1'b0;
        cin_seen = cin1; b_seen = b1;
        lat = 0; lowc = 0;
        while (lat < 30) begin
            if (!rdy1) lowc++;
            @(posedge clk); #1; lat++;
            if (d1) break;
        end
    endtask

    task automatic op3(input logic ld, input logic [2:0] op, input logic [7:0] opd,
                       output int lat);
        int k;
        k = 0;
        while (!rdy3 && k < 50) begin @(posedge clk); #1; k++; end
        v3 = 1'b1; ld3 = ld; op3s = op; opd3 = opd; uc3 = 1'b0;
        @(posedge clk); #1;
        v3 = 1'b0;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk); #1; lat++;
            if (d3) break;
        end
    endtask

    task automatic test_reset();
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rdy1); end
        checks++; if ({acc1, c1, z1, n1, d1} !== 12'd0) begin errors++;
            $display("FAIL reset_state got acc=%0d c=%b z=%b n=%b done=%b want all 0", acc1, c1, z1, n1, d1); end
        checks++; if ({b1, aop1, cin1} !== 12'd0) begin errors++;
            $display("FAIL reset_alu_pins got b=%0d op=%0d cin=%b want 0", b1, aop1, cin1); end
        checks++; if ({acc3, rdy3, d3} !== 10'b0000_0000_10) begin errors++;
            $display("FAIL reset_u3 got acc=%0d rdy=%b done=%b want 0/1/0", acc3, rdy3, d3); end
    endtask

    task automatic test_load_add();
        int lat, lowc; logic cs; logic [7:0] bs;
        op1(1'b1, 3'b000, 8'd7, 1'b0, lat, lowc, cs, bs);
        checks++; if ({acc1, c1, z1, n1} !== {8'd7, 3'b000}) begin errors++;
            $display("FAIL load7 got acc=%0d c=%b z=%b n=%b want 7/0/0/0", acc1, c1, z1, n1); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d want 2", lat); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL ready_in_done got %b want 1", rdy1); end
        @(posedge clk); #1;
        checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", d1); end
        op1(1'b0, 3'b000, 8'd8, 1'b0, lat, lowc, cs, bs);
        checks++; if (bs !== 8'd8) begin errors++; $display("FAIL add_alu_b got %0d want 8", bs); end
        checks++; if ({acc1, c1, z1, n1} !== {8'd15, 3'b000}) begin errors++;
            $display("FAIL add8 got acc=%0d c=%b z=%b n=%b want 15/0/0/0", acc1, c1, z1, n1); end
        checks++; if (lat !== 2 || lowc !== 2) begin errors++;
            $display("FAIL add_timing got lat=%0d low=%0d want 2/2", lat, lowc); end
        checks++; if (a1 !== 8'd15) begin errors++; $display("FAIL alu_a_follows_acc got %0d want 15", a1); end
    endtask

    task automatic test_carry_out();
        int lat, lowc; logic cs; logic [7:0] bs;
        op1(1'b1, 3'b000, 8'd200, 1'b0, lat, lowc, cs, bs);
        checks++; if ({acc1, n1} !== {8'd200, 1'b1}) begin errors++;
            $display("FAIL load200 got acc=%0d n=%b want 200/1", acc1, n1); end
        op1(1'b0, 3'b000, 8'd100, 1'b0, lat, lowc, cs, bs);
        checks++; if ({acc1, c1, z1, n1} !== {8'd44, 3'b100}) begin errors++;
            $display("FAIL add100 got acc=%0d c=%b z=%b n=%b want 44/1/0/0", acc1, c1, z1, n1); end
    endtask

    task automatic test_carry_chain();
        int lat, lowc; logic cs; logic [7:0] bs;
        op1(1'b1, 3'b000, 8'd0, 1'b0, lat, lowc, cs, bs);
        checks++; if ({acc1, c1, z1, n1} !== {8'd0, 3'b110}) begin errors++;
            $display("FAIL load0 got acc=%0d c=%b z=%b n=%b want 0/1/1/0", acc1, c1, z1, n1); end
        op1(1'b0, 3'b000, 8'd0, 1'b1, lat, lowc, cs, bs);
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL chain_cin got %b want 1", cs); end
        checks++; if ({acc1, c1, z1, n1} !== {8'd1, 3'b000}) begin errors++;
            $display("FAIL chain_add got acc=%0d c=%b z=%b n=%b want 1/0/0/0", acc1, c1, z1, n1); end
        // use_carry with C=0 must give cin 0
        op1(1'b0, 3'b000, 8'd2, 1'b1, lat, lowc, cs, bs);
        checks++; if (cs !== 1'b0 || acc1 !== 8'd3) begin errors++;
            $display("FAIL chain_cin0 got cin=%b acc=%0d want 0/3", cs, acc1); end
    endtask

    task automatic test_back_pressure();
        int k, lat, lowc; logic [7:0] bmid;
        k = 0;
        while (!rdy3 && k < 50) begin @(posedge clk); #1; k++; end
        v3 = 1'b1; ld3 = 1'b1; op3s = 3'b000; opd3 = 8'd10; uc3 = 1'b0;
        @(posedge clk); #1;
        v3 = 1'b0;
        lat = 0; lowc = 0; bmid = 8'd0;
        while (lat < 30) begin
            if (!rdy3) lowc++;
            if (lat == 0) begin v3 = 1'b1; ld3 = 1'b0; opd3 = 8'd99; end
            @(posedge clk); #1; lat++;
            v3 = 1'b0;
            if (lat == 1) bmid = b3;
            if (d3) break;
        end
        checks++; if (bmid !== 8'd10) begin errors++; $display("FAIL bp_alu_b_held got %0d want 10", bmid); end
        checks++; if (acc3 !== 8'd10) begin errors++; $display("FAIL bp_acc got %0d want 10", acc3); end
        checks++; if (lat !== 4 || lowc !== 4) begin errors++;
            $display("FAIL bp_timing got lat=%0d low=%0d want 4/4", lat, lowc); end
        @(posedge clk); #1;
        checks++; if (rdy3 !== 1'b1 || d3 !== 1'b0) begin errors++;
            $display("FAIL bp_no_queue got rdy=%b done=%b want 1/0", rdy3, d3); end
    endtask

    task automatic test_reset_mid_op();
        int k, lat, dseen;
        k = 0;
        while (!rdy3 && k < 50) begin @(posedge clk); #1; k++; end
        v3 = 1'b1; ld3 = 1'b0; op3s = 3'b000; opd3 = 8'd3; uc3 = 1'b0;
        @(posedge clk); #1;
        v3 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({acc3, c3, z3, n3, d3} !== 12'd0) begin errors++;
            $display("FAIL midrst_state got acc=%0d c=%b z=%b n=%b done=%b want 0", acc3, c3, z3, n3, d3); end
        checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", rdy3); end
        dseen = 0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (d3) dseen++; end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin @(posedge clk); #1; if (d3) dseen++; end
        checks++; if (dseen !== 0 || acc3 !== 8'd0) begin errors++;
            $display("FAIL midrst_no_write got done_pulses=%0d acc=%0d want 0/0", dseen, acc3); end
        op3(1'b1, 3'b000, 8'd5, lat);
        checks++; if (acc3 !== 8'd5 || lat !== 4) begin errors++;
            $display("FAIL postrst_load got acc=%0d lat=%0d want 5/4", acc3, lat); end
    endtask

    task automatic test_overflow();
        int lat, lowc; logic cs; logic [7:0] bs;
        op1(1'b1, 3'b000, 8'd100, 1'b0, lat, lowc, cs, bs);
        op1(1'b0, 3'b000, 8'd100, 1'b0, lat, lowc, cs, bs);
        checks++; if ({acc1, c1, z1, n1} !== {8'd200, 3'b001}) begin errors++;
            $display("FAIL ovf_add got acc=%0d c=%b z=%b n=%b want 200/0/0/1", acc1, c1, z1, n1); end
`ifdef ACC_EXEC8_OVF_FLAG_EN
        checks++; if (fv1 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", fv1); end
        op1(1'b1, 3'b000, 8'd1, 1'b0, lat, lowc, cs, bs);
        checks++; if (fv1 !== 1'b1) begin errors++; $display("FAIL ovf_hold_on_load got %b want 1", fv1); end
        op1(1'b0, 3'b001, 8'd3, 1'b0, lat, lowc, cs, bs);
        checks++; if (fv1 !== 1'b0 || acc1 !== 8'd2) begin errors++;
            $display("FAIL ovf_clear_xor got v=%b acc=%0d want 0/2", fv1, acc1); end
`endif
    endtask

    initial begin
        v1 = 1'b0; ld1 = 1'b0; op1s = 3'd0; opd1 = 8'd0; uc1 = 1'b0;
        v3 = 1'b0; ld3 = 1'b0; op3s = 3'd0; opd3 = 8'd0; uc3 = 1'b0;
        #23;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_load_add();
        test_carry_out();
        test_carry_chain();
        test_back_pressure();
        test_reset_mid_op();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

endmodule
